// File: rtl/matmul_pkg.sv
// Shared constants, FSM state encoding and delay-line tag for the matrix-multiply issue controller.
// The optional issue stall is enabled by defining MATMUL_CTRL_STALL_EN.
package matmul_pkg;

    localparam int DIM       = 4;
    localparam int IDX_W     = $clog2(DIM);
    localparam int ADDR_W    = 2 * IDX_W;
    localparam int RD_LAT    = 1;
    localparam int MAC_LAT   = 3;
    localparam int TAG_DEPTH = RD_LAT + MAC_LAT;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              first;
        logic              last;
        logic [ADDR_W-1:0] c_addr;
    } tag_t;

    // Row-major flat address of element (row, col); DIM is a power of two.
    function automatic logic [ADDR_W-1:0] flat_addr(input logic [IDX_W-1:0] row,
                                                    input logic [IDX_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/matmul_tag_delay.sv
// Fixed-depth shift register carrying issue tags alongside the operand read and MAC pipe.
// Stage 0 is aligned with the issue cycle; stage s lags it by s cycles.
module matmul_tag_delay
    import matmul_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  tag_t             in_tag,
    output tag_t [DEPTH-1:0] stages,
    output logic             any_vld
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= in_tag;
            for (int s = 1; s < DEPTH; s++) begin
                stages[s] <= stages[s-1];
            end
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            any_vld = any_vld | stages[s].vld;
        end
    end

endmodule

// File: rtl/matmul_issue_ctrl.sv
// Issue sequencer for the NxN matrix-multiply datapath: walks i,j,k, strobes operand reads,
// and aligns MAC and C write-back strobes. Define MATMUL_CTRL_STALL_EN to add the stall input.
module matmul_issue_ctrl
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_vld,
    output logic              mac_clr,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr
`ifdef MATMUL_CTRL_STALL_EN
    ,
    input  logic              stall
`endif
);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       i;
    logic [IDX_W-1:0]       j;
    logic [IDX_W-1:0]       k;
    logic                   hold;
    logic                   issue;
    logic                   last_idx;
    tag_t                   in_tag;
    tag_t [TAG_DEPTH-1:0]   stages;
    logic                   any_vld;
    logic                   unused_stage_bits;

`ifdef MATMUL_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign last_idx = (i == IDX_MAX) && (j == IDX_MAX) && (k == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits until the last issued tag has left the delay line, so done follows the final c_we.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        in_tag     = '0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                issue = !hold;
                if (issue && last_idx) state_next = DRAIN;
            end
            DRAIN:   if (!any_vld) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (issue) begin
            in_tag.vld    = 1'b1;
            in_tag.first  = (k == '0);
            in_tag.last   = (k == IDX_MAX);
            in_tag.c_addr = flat_addr(i, j);
        end
    end

    matmul_tag_delay #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .in_tag  (in_tag),
        .stages  (stages),
        .any_vld (any_vld)
    );

    // Operands reach the MAC RD_LAT cycles after the read strobe.
    assign mac_vld = stages[RD_LAT].vld;
    assign mac_clr = stages[RD_LAT].vld & stages[RD_LAT].first;

    // Only a few tag fields are tapped; the rest exist to carry the tag down the line.
    assign unused_stage_bits = ^stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_en  <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
            c_we   <= 1'b0;
            c_addr <= '0;
        end else begin
            busy  <= (state == RUN) || (state == DRAIN);
            done  <= (state == DRAIN) && (state_next == DONE);
            rd_en <= issue;
            c_we  <= stages[TAG_DEPTH-1].vld && stages[TAG_DEPTH-1].last;
            if (stages[TAG_DEPTH-1].vld && stages[TAG_DEPTH-1].last) begin
                c_addr <= stages[TAG_DEPTH-1].c_addr;
            end
            if ((state == IDLE) && start) begin
                i <= '0;
                j <= '0;
                k <= '0;
            end else if (issue) begin
                a_addr <= flat_addr(i, k);
                b_addr <= flat_addr(k, j);
                k      <= k + 1'b1;
                if (k == IDX_MAX) begin
                    j <= j + 1'b1;
                    if (j == IDX_MAX) begin
                        i <= i + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_issue_ctrl.sv
// Directed testbench for matmul_issue_ctrl with behavioural operand memories, a reference MAC pipe
// and a scoreboard of expected C writes and done pulses.
module tb_matmul_issue_ctrl;
    import matmul_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stall;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              mac_vld;
    logic              mac_clr;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [51:0] exp_q[$];
    logic [31:0] done_q[$];

    logic [7:0]  mem_a [DIM*DIM];
    logic [7:0]  mem_b [DIM*DIM];
    logic [15:0] c_obs [DIM*DIM];
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_s1;
    logic [15:0] acc_s2;
    logic [15:0] acc_s3;

    matmul_issue_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .mac_vld (mac_vld),
        .mac_clr (mac_clr),
        .c_we    (c_we),
        .c_addr  (c_addr)
`ifdef MATMUL_CTRL_STALL_EN
        ,
        .stall   (stall)
`endif
    );

    // ---- clock / cycle counter ----
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- behavioural operand memories (1-cycle read) and MAC pipe (3 cycles to result) ----
    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
        if (mac_vld) acc_s1 <= mac_clr ? 16'(a_q) * 16'(b_q) : acc_s1 + 16'(a_q) * 16'(b_q);
        acc_s2 <= acc_s1;
        acc_s3 <= acc_s2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_stall(input int r, input bit on);
        return on && (((r >= 5) && (r <= 7)) || (r == 40));
    endfunction

    // Cycle (relative to the start edge) at which issue n happens.
    function automatic int issue_rel(input int n, input bit on);
        int cnt = 0;
        for (int r = 1; r < 1000; r++) begin
            if (!is_stall(r, on)) begin
                if (cnt == n) return r;
                cnt++;
            end
        end
        return -1;
    endfunction

    function automatic logic [15:0] golden(input int e);
        logic [15:0] s = '0;
        int ri = e / DIM;
        int cj = e % DIM;
        for (int kk = 0; kk < DIM; kk++) s += 16'(mem_a[ri*DIM+kk]) * 16'(mem_b[kk*DIM+cj]);
        return s;
    endfunction

    // ---- scoreboard: compare C writes and done pulses as they appear ----
    always @(negedge clk) begin
        logic [51:0] e;
        if (!rst) begin
            if (c_we) begin
                c_obs[c_addr] = acc_s3;
                if (exp_q.size() == 0) begin
                    check("c_we_unexpected", 32'(c_we), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("c_we_cycle", cyc, e[51:20]);
                    check("c_addr", 32'(c_addr), 32'(e[19:16]));
                    check("c_data", 32'(acc_s3), 32'(e[15:0]));
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", 32'(done), 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // ---- driver tasks ----
    task automatic expect_run(input int t0, input bit stall_on);
        int r;
        for (int e = 0; e < DIM*DIM; e++) begin
            r = issue_rel(DIM*e + DIM - 1, stall_on) + RD_LAT + MAC_LAT;
            exp_q.push_back({32'(t0 + r), 4'(e), golden(e)});
        end
        done_q.push_back(32'(t0 + issue_rel(DIM*DIM*DIM - 1, stall_on) + RD_LAT + MAC_LAT + 1));
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic wait_run(input int t0, input bit hold, input bit poke, input bit stall_on);
        int  rel;
        int  rd_cnt   = 0;
        int  rd_bad   = 0;
        int  busy_bad = 0;
        bit  got_done = 0;
        int  last_rel = issue_rel(DIM*DIM*DIM - 1, stall_on);
        bit  exp_rd;
        for (int w = 0; (w < 200) && !got_done; w++) begin
            @(negedge clk);
            rel = cyc - t0;
            if ((rel == 0) && !hold) start = 1'b0;
            if (poke && ((rel == 9) || (rel == 39))) start = 1'b1;
            if (poke && ((rel == 10) || (rel == 40))) start = 1'b0;
            stall = is_stall(rel + 1, stall_on);
            if (rel >= 0) begin
                exp_rd = (rel >= 1) && (rel <= last_rel) && !is_stall(rel, stall_on);
                if (rd_en !== exp_rd) rd_bad++;
                if (rd_en === 1'b1) rd_cnt++;
                if (busy !== (rel >= 1)) busy_bad++;
            end
            if (rel == 1) begin
                check("first_a_addr", 32'(a_addr), 0);
                check("first_b_addr", 32'(b_addr), 0);
            end
            if (rel == 2) check("first_mac_vld_clr", {30'd0, mac_vld, mac_clr}, 3);
            if (done === 1'b1) got_done = 1'b1;
        end
        stall = 1'b0;
        check("run_timeout", 32'(got_done), 1);
        check("rd_en_count", rd_cnt, DIM*DIM*DIM);
        check("rd_en_pattern", rd_bad, 0);
        check("busy_pattern", busy_bad, 0);
    endtask

    task automatic post_run_idle();
        repeat (3) @(negedge clk);
        check("idle_outputs", {29'd0, busy, done, rd_en}, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
    endtask

    task automatic load_random();
        for (int e = 0; e < DIM*DIM; e++) begin
            mem_a[e] = 8'($urandom_range(0, 15));
            mem_b[e] = 8'($urandom_range(0, 15));
        end
    endtask

    // ---- directed sequence ----
    initial begin
        int t0;
        int bad;
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        load_random();
        repeat (3) @(negedge clk);
        check("reset_outputs", {14'd0, busy, done, rd_en, mac_vld, mac_clr, c_we, a_addr, b_addr, c_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single start pulse, random operands
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 0, 0, 0);
        post_run_idle();

        // 2: identity A, ramp B -> C == B; then ramp A, identity B -> C == A
        for (int e = 0; e < DIM*DIM; e++) begin
            mem_a[e] = ((e / DIM) == (e % DIM)) ? 8'd1 : 8'd0;
            mem_b[e] = 8'(e);
        end
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 0, 0, 0);
        post_run_idle();
        bad = 0;
        for (int e = 0; e < DIM*DIM; e++) if (c_obs[e] !== 16'(mem_b[e])) bad++;
        check("c_equals_b", bad, 0);
        for (int e = 0; e < DIM*DIM; e++) begin
            mem_a[e] = 8'(15 - e);
            mem_b[e] = ((e / DIM) == (e % DIM)) ? 8'd1 : 8'd0;
        end
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 0, 0, 0);
        post_run_idle();
        bad = 0;
        for (int e = 0; e < DIM*DIM; e++) if (c_obs[e] !== 16'(mem_a[e])) bad++;
        check("c_equals_a", bad, 0);

        // 3: start pulses during RUN are ignored
        load_random();
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 0, 1, 0);
        repeat (40) @(negedge clk);
        check("no_retrigger_busy", 32'(busy), 0);
        post_run_idle();

        // 4: reset mid-run aborts, then a full run from address 0
        pulse_start(t0);
        expect_run(t0, 0);
        @(negedge clk);
        start = 1'b0;
        while ((cyc - t0) < 30) @(negedge clk);
        check("pre_abort_rd_en", 32'(rd_en), 1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {14'd0, busy, done, rd_en, mac_vld, mac_clr, c_we, a_addr, b_addr, c_addr}, 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if ((c_we === 1'b1) || (done === 1'b1) || (rd_en === 1'b1)) cnt++;
        end
        check("abort_silence", cnt, 0);
        load_random();
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 0, 0, 0);
        post_run_idle();

        // 5: start held high -> back-to-back runs, second start edge two cycles after done
        load_random();
        pulse_start(t0);
        expect_run(t0, 0);
        wait_run(t0, 1, 0, 0);
        expect_run(t0 + 71, 0);
        wait_run(t0 + 71, 0, 0, 0);
        post_run_idle();

`ifdef MATMUL_CTRL_STALL_EN
        // 6: stall on cycles 5-7 and 40 delays completion by four cycles
        load_random();
        pulse_start(t0);
        expect_run(t0, 1);
        wait_run(t0, 0, 0, 1);
        post_run_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
